// File: rtl/particle_stream_feeder_if.sv
// Bus bundle between the particle stream feeder, its particle RAM and the electrostatics top.
// The feeder takes the master side; the RAM/top (or a bench) takes the slave side.
interface particle_stream_feeder_if #(
    parameter int ADDR_WIDTH = 11,
    parameter int DATA_WIDTH = 128
);
    logic                  go;
    logic                  phase1_done;
    logic                  mem_rd_en;
    logic [ADDR_WIDTH-1:0] mem_rd_addr;
    logic [DATA_WIDTH-1:0] mem_rd_data;
    logic [1:0]            start_sig;
    logic [DATA_WIDTH-1:0] user_buffer_data;
    logic                  user_data_available;
    logic                  busy;
    logic                  done;

    modport master (
        input  go, phase1_done, mem_rd_data,
        output mem_rd_en, mem_rd_addr, start_sig, user_buffer_data,
               user_data_available, busy, done
    );

    modport slave (
        output go, phase1_done, mem_rd_data,
        input  mem_rd_en, mem_rd_addr, start_sig, user_buffer_data,
               user_data_available, busy, done
    );
endinterface

// File: rtl/particle_stream_feeder.sv
// Two-pass particle streamer: reads records from the particle RAM one word ahead and presents
// each for WORD_INTERVAL cycles, pausing between passes until the top reports phase-1 completion.
module particle_stream_feeder #(
    parameter int NUM_PARTICLES = 2048,
    parameter int ADDR_WIDTH    = 11,
    parameter int DATA_WIDTH    = 128,
    parameter int WORD_INTERVAL = 4,
    parameter int LEAD_CYCLES   = 5
) (
    input  logic                      clk,
    input  logic                      rst,
    particle_stream_feeder_if.master  io_feed
);
    localparam int WW     = ADDR_WIDTH + 1;
    localparam int CNT_MAX = (LEAD_CYCLES > WORD_INTERVAL) ? LEAD_CYCLES : WORD_INTERVAL;
    localparam int CW     = $clog2(CNT_MAX + 1);

    localparam logic [WW-1:0] NUM_W     = WW'(NUM_PARTICLES);
    localparam logic [WW-1:0] LAST_WORD = WW'(NUM_PARTICLES - 1);
    localparam logic [CW-1:0] LEAD_LAST = CW'(LEAD_CYCLES - 1);
    localparam logic [CW-1:0] WORD_LAST = CW'(WORD_INTERVAL - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ARM,
        S_STREAM,
        S_WAIT,
        S_FIN
    } state_t;

    state_t                r_state,    w_state;
    logic                  r_pass2,    w_pass2;
    logic                  r_flag,     w_flag;
    logic [CW-1:0]         r_cnt,      w_cnt;
    logic [WW-1:0]         r_word,     w_word;
    logic                  r_rd_en,    w_rd_en;
    logic [ADDR_WIDTH-1:0] r_rd_addr,  w_rd_addr;
    logic                  r_cap,      w_cap;
    logic [DATA_WIDTH-1:0] r_prefetch, w_prefetch;
    logic [DATA_WIDTH-1:0] r_data,     w_data;
    logic                  r_uda,      w_uda;
    logic [1:0]            r_start,    w_start;
    logic                  r_done,     w_done;

    logic [DATA_WIDTH-1:0] w_fetch;
    logic [WW-1:0]         w_word_inc;
    logic [WW-1:0]         w_word_inc2;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state    <= S_IDLE;
            r_pass2    <= 1'b0;
            r_flag     <= 1'b0;
            r_cnt      <= '0;
            r_word     <= '0;
            r_rd_en    <= 1'b0;
            r_rd_addr  <= '0;
            r_cap      <= 1'b0;
            r_prefetch <= '0;
            r_data     <= '0;
            r_uda      <= 1'b0;
            r_start    <= 2'd0;
            r_done     <= 1'b0;
        end else begin
            r_state    <= w_state;
            r_pass2    <= w_pass2;
            r_flag     <= w_flag;
            r_cnt      <= w_cnt;
            r_word     <= w_word;
            r_rd_en    <= w_rd_en;
            r_rd_addr  <= w_rd_addr;
            r_cap      <= w_cap;
            r_prefetch <= w_prefetch;
            r_data     <= w_data;
            r_uda      <= w_uda;
            r_start    <= w_start;
            r_done     <= w_done;
        end
    end

    // Read data arriving this cycle bypasses the prefetch register, so the shortest lead and
    // word intervals still present the freshly read record.
    always_comb begin
        w_fetch     = r_cap ? io_feed.mem_rd_data : r_prefetch;
        w_word_inc  = r_word + WW'(1);
        w_word_inc2 = r_word + WW'(2);

        w_state    = r_state;
        w_pass2    = r_pass2;
        w_flag     = r_flag;
        w_cnt      = r_cnt;
        w_word     = r_word;
        w_rd_en    = 1'b0;
        w_rd_addr  = r_rd_addr;
        w_cap      = r_rd_en;
        w_prefetch = w_fetch;
        w_data     = r_data;
        w_uda      = r_uda;
        w_start    = r_start;
        w_done     = 1'b0;

        case (r_state)
            S_IDLE: begin
                if (io_feed.go) begin
                    w_state   = S_ARM;
                    w_pass2   = 1'b0;
                    w_flag    = 1'b0;
                    w_start   = 2'd1;
                    w_rd_en   = 1'b1;
                    w_rd_addr = '0;
                    w_cnt     = '0;
                end
            end
            S_ARM: begin
                if (!r_pass2 && io_feed.phase1_done) w_flag = 1'b1;
                if (r_cnt == LEAD_LAST) begin
                    w_state = S_STREAM;
                    w_cnt   = '0;
                    w_word  = '0;
                    w_data  = w_fetch;
                    w_uda   = 1'b1;
                    if (NUM_PARTICLES > 1) begin
                        w_rd_en   = 1'b1;
                        w_rd_addr = ADDR_WIDTH'(1);
                    end
                end else begin
                    w_cnt = r_cnt + CW'(1);
                end
            end
            S_STREAM: begin
                if (!r_pass2 && io_feed.phase1_done) w_flag = 1'b1;
                if (r_cnt == WORD_LAST) begin
                    w_cnt = '0;
                    if (r_word == LAST_WORD) begin
                        w_uda = 1'b0;
                        if (r_pass2) begin
                            w_state = S_FIN;
                            w_done  = 1'b1;
                            w_start = 2'd0;
                        end else begin
                            w_state = S_WAIT;
                        end
                    end else begin
                        w_word = w_word_inc;
                        w_data = w_fetch;
                        if (w_word_inc2 < NUM_W) begin
                            w_rd_en   = 1'b1;
                            w_rd_addr = w_word_inc2[ADDR_WIDTH-1:0];
                        end
                    end
                end else begin
                    w_cnt = r_cnt + CW'(1);
                end
            end
            S_WAIT: begin
                if (r_flag || io_feed.phase1_done) begin
                    w_state   = S_ARM;
                    w_pass2   = 1'b1;
                    w_flag    = 1'b0;
                    w_start   = 2'd2;
                    w_rd_en   = 1'b1;
                    w_rd_addr = '0;
                    w_cnt     = '0;
                end
            end
            S_FIN: begin
                w_state = S_IDLE;
            end
            default: begin
                w_state = S_IDLE;
            end
        endcase
    end

    assign io_feed.mem_rd_en           = r_rd_en;
    assign io_feed.mem_rd_addr         = r_rd_addr;
    assign io_feed.start_sig           = r_start;
    assign io_feed.user_buffer_data    = r_data;
    assign io_feed.user_data_available = r_uda;
    assign io_feed.busy                = (r_state != S_IDLE);
    assign io_feed.done                = r_done;
endmodule

// File: tb/tb_particle_stream_feeder.sv
// Bench for particle_stream_feeder: a small 4-word instance against a timing-formula model with
// random stimulus, plus a full-size 2048-word instance checked by counting.
module tb_particle_stream_feeder;
    localparam int N        = 4;
    localparam int AW       = 3;
    localparam int DW       = 128;
    localparam int W        = 4;
    localparam int LEAD     = 5;
    localparam int PASS_LEN = LEAD + N * W;
    localparam int BN       = 2048;
    localparam int BAW      = 11;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic rstBig = 1'b1;
    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    particle_stream_feeder_if #(.ADDR_WIDTH(AW),  .DATA_WIDTH(DW)) sIf ();
    particle_stream_feeder_if #(.ADDR_WIDTH(BAW), .DATA_WIDTH(DW)) bIf ();

    particle_stream_feeder #(.NUM_PARTICLES(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW),
                             .WORD_INTERVAL(W), .LEAD_CYCLES(LEAD))
        dutSmall (.clk(clk), .rst(rst), .io_feed(sIf));

    particle_stream_feeder #(.NUM_PARTICLES(BN), .ADDR_WIDTH(BAW), .DATA_WIDTH(DW),
                             .WORD_INTERVAL(W), .LEAD_CYCLES(LEAD))
        dutBig (.clk(clk), .rst(rstBig), .io_feed(bIf));

    logic [DW-1:0] ramS [0:7];

    function automatic logic [DW-1:0] bigWord(input int a);
        logic [31:0] av;
        av = a;
        return {av, ~av, av * 32'd3, 32'hA5A5_0000 ^ av};
    endfunction

    always @(posedge clk) if (sIf.mem_rd_en) sIf.mem_rd_data <= ramS[sIf.mem_rd_addr];
    always @(posedge clk) if (bIf.mem_rd_en) bIf.mem_rd_data <= bigWord(int'(bIf.mem_rd_addr));

    task automatic checkOutput(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Reference model: each pass is described by its start edge; outputs follow from offsets.
    int cyc = 0;
    int mMode = 0;
    int mStart = 0;
    bit mLatched = 0;
    logic [DW-1:0] mHeld = '0;
    int rdSeen = 0;
    int rel, kIdx;
    bit passEnd, expRd, expUda;
    logic [AW-1:0] expAddr;
    logic [1:0] expStart;

    always @(posedge clk) begin
        cyc++;
        passEnd = 0;
        if (!rst) begin
            mMode = 0; mLatched = 0; mHeld = '0; rdSeen = 0;
        end else begin
            case (mMode)
                0: if (sIf.go) begin mMode = 1; mStart = cyc; mLatched = 0; end
                1: begin
                    if (sIf.phase1_done) mLatched = 1;
                    if (cyc == mStart + PASS_LEN) begin mMode = 2; passEnd = 1; end
                end
                2: if (mLatched || sIf.phase1_done) begin mMode = 3; mStart = cyc; mLatched = 0; end
                3: if (cyc == mStart + PASS_LEN) begin mMode = 4; passEnd = 1; end
                default: mMode = 0;
            endcase
        end
        rel = cyc - mStart;
        expRd = 0; expUda = 0; expAddr = '0;
        if (mMode == 1 || mMode == 3) begin
            if (rel == 0) begin
                expRd = 1;
            end else if (rel >= LEAD && rel < PASS_LEN) begin
                expUda = 1;
                kIdx = (rel - LEAD) / W;
                if ((rel - LEAD) % W == 0) begin
                    mHeld = ramS[kIdx];
                    if (kIdx + 1 < N) begin expRd = 1; expAddr = AW'(kIdx + 1); end
                end
            end
        end
        expStart = (mMode == 1 || mMode == 2) ? 2'd1 : (mMode == 3) ? 2'd2 : 2'd0;
        #1;
        checkOutput("start_sig", 128'(sIf.start_sig), 128'(expStart));
        checkOutput("uda", 128'(sIf.user_data_available), 128'(expUda));
        checkOutput("busy", 128'(sIf.busy), 128'(mMode != 0));
        checkOutput("done", 128'(sIf.done), 128'(mMode == 4));
        checkOutput("rd_en", 128'(sIf.mem_rd_en), 128'(expRd));
        checkOutput("data", sIf.user_buffer_data, mHeld);
        if (sIf.mem_rd_en) begin
            rdSeen++;
            checkOutput("rdAddrRange", 128'(sIf.mem_rd_addr < AW'(N)), 128'(1));
        end
        if (expRd) checkOutput("rd_addr", 128'(sIf.mem_rd_addr), 128'(expAddr));
        if (passEnd) begin
            checkOutput("readsPerPass", 128'(rdSeen), 128'(N));
            rdSeen = 0;
        end
    end

    int bUda1 = 0, bUda2 = 0, bRd1 = 0, bRd2 = 0, bDone = 0, bLastAddr = -1;
    always @(posedge clk) begin
        #1;
        if (bIf.user_data_available) begin
            if (bIf.start_sig == 2'd1) bUda1++;
            else if (bIf.start_sig == 2'd2) bUda2++;
        end
        if (bIf.mem_rd_en) begin
            if (bIf.start_sig == 2'd1) bRd1++;
            else if (bIf.start_sig == 2'd2) bRd2++;
            bLastAddr = int'(bIf.mem_rd_addr);
        end
        if (bIf.done) bDone++;
    end

    task automatic pulseGo();
        @(negedge clk); sIf.go = 1'b1;
        @(negedge clk); sIf.go = 1'b0;
    endtask

    task automatic pulsePd();
        @(negedge clk); sIf.phase1_done = 1'b1;
        @(negedge clk); sIf.phase1_done = 1'b0;
    endtask

    task automatic waitSmallDone(input int limit);
        bit seen = 0;
        for (int i = 0; i < limit && !seen; i++) begin
            @(negedge clk);
            if (sIf.done) seen = 1;
        end
        checkOutput("smallDoneSeen", 128'(seen), 128'(1));
        @(negedge clk);
        checkOutput("afterDoneBusy", 128'(sIf.busy), 128'(0));
        checkOutput("afterDoneStart", 128'(sIf.start_sig), 128'(0));
    endtask

    task automatic fillRam(input bit pattern);
        for (int i = 0; i < 8; i++) begin
            logic [31:0] iv = i;
            if (pattern) ramS[i] = {iv, iv, iv, 32'd0};
            else ramS[i] = {$urandom, $urandom, $urandom, $urandom};
        end
    endtask

    // Random scenario: spurious go and phase1_done pulses anywhere after a start.
    task automatic applyStimulus(input int seedIdx);
        bit seen = 0;
        fillRam(0);
        repeat ($urandom_range(0, 5)) @(negedge clk);
        if ((seedIdx % 2) == 1) pulsePd();
        pulseGo();
        for (int i = 0; i < 120 && !seen; i++) begin
            @(negedge clk);
            if (sIf.done) seen = 1;
            sIf.phase1_done = (i >= 60) ? !seen : ($urandom_range(0, 9) == 0);
            sIf.go = !seen && ($urandom_range(0, 14) == 0);
        end
        sIf.go = 1'b0;
        sIf.phase1_done = 1'b0;
        checkOutput("randDoneSeen", 128'(seen), 128'(1));
        @(negedge clk);
    endtask

    initial begin
        fillRam(1);
        sIf.go = 0; sIf.phase1_done = 0; sIf.mem_rd_data = '0;
        bIf.go = 0; bIf.phase1_done = 0; bIf.mem_rd_data = '0;
        #1 rst = 1'b0; rstBig = 1'b0;
        #1;
        checkOutput("resetStart", 128'(sIf.start_sig), 128'(0));
        checkOutput("resetData", sIf.user_buffer_data, 128'(0));
        checkOutput("resetBusy", 128'(sIf.busy), 128'(0));
        repeat (3) @(negedge clk);
        rst = 1'b1; rstBig = 1'b1;
        repeat (2) @(negedge clk);

        $display("[TB] basic two-pass");
        pulseGo();
        checkOutput("basicStart1", 128'(sIf.start_sig), 128'(1));
        checkOutput("basicRd0", 128'(sIf.mem_rd_en), 128'(1));
        checkOutput("basicAddr0", 128'(sIf.mem_rd_addr), 128'(0));
        repeat (LEAD) @(negedge clk);
        checkOutput("basicWord0Uda", 128'(sIf.user_data_available), 128'(1));
        checkOutput("basicWord0", sIf.user_buffer_data, 128'(0));
        repeat (W) @(negedge clk);
        checkOutput("basicWord1", sIf.user_buffer_data, {32'd1, 32'd1, 32'd1, 32'd0});
        repeat (3 * W) @(negedge clk);
        checkOutput("basicEndUda", 128'(sIf.user_data_available), 128'(0));
        checkOutput("basicHold", sIf.user_buffer_data, {32'd3, 32'd3, 32'd3, 32'd0});
        repeat (19) @(negedge clk);
        checkOutput("basicWaitStart", 128'(sIf.start_sig), 128'(1));
        pulsePd();
        checkOutput("basicStart2", 128'(sIf.start_sig), 128'(2));
        checkOutput("basicRd2", 128'(sIf.mem_rd_en), 128'(1));
        waitSmallDone(60);

        $display("[TB] early completion");
        fillRam(0);
        pulseGo();
        repeat (7) @(negedge clk);
        pulsePd();
        repeat (12) @(negedge clk);
        checkOutput("earlyWaitStart", 128'(sIf.start_sig), 128'(1));
        @(negedge clk);
        checkOutput("earlyStart2", 128'(sIf.start_sig), 128'(2));
        waitSmallDone(60);

        $display("[TB] go during stream");
        pulseGo();
        repeat (10) @(negedge clk);
        pulseGo();
        repeat (20) @(negedge clk);
        pulsePd();
        waitSmallDone(60);

        $display("[TB] phase1_done in idle");
        pulsePd();
        repeat (2) @(negedge clk);
        pulseGo();
        repeat (PASS_LEN + 10) @(negedge clk);
        checkOutput("idlePdStillWaiting", 128'(sIf.busy), 128'(1));
        checkOutput("idlePdStart", 128'(sIf.start_sig), 128'(1));
        pulsePd();
        waitSmallDone(60);

        $display("[TB] reset mid-stream");
        fillRam(0);
        pulseGo();
        repeat (14) @(negedge clk);
        rst = 1'b0;
        #1;
        checkOutput("rstData", sIf.user_buffer_data, 128'(0));
        checkOutput("rstUda", 128'(sIf.user_data_available), 128'(0));
        checkOutput("rstStart", 128'(sIf.start_sig), 128'(0));
        checkOutput("rstRd", 128'(sIf.mem_rd_en), 128'(0));
        checkOutput("rstBusy", 128'(sIf.busy), 128'(0));
        repeat (2) @(negedge clk);
        rst = 1'b1;
        repeat (30) @(negedge clk);
        pulseGo();
        repeat (LEAD) @(negedge clk);
        checkOutput("restartWord0", sIf.user_buffer_data, ramS[0]);
        repeat (30) @(negedge clk);
        pulsePd();
        waitSmallDone(60);

        $display("[TB] random scenarios");
        for (int s = 0; s < 10; s++) applyStimulus(s);

        $display("[TB] full size");
        @(negedge clk); bIf.go = 1'b1;
        @(negedge clk); bIf.go = 1'b0;
        repeat (LEAD + BN * W + 2) @(negedge clk);
        checkOutput("bigUda1", 128'(bUda1), 128'(8192));
        checkOutput("bigRd1", 128'(bRd1), 128'(2048));
        checkOutput("bigLastAddr1", 128'(bLastAddr), 128'(2047));
        checkOutput("bigHold1", bIf.user_buffer_data, bigWord(2047));
        checkOutput("bigWaitUda", 128'(bIf.user_data_available), 128'(0));
        @(negedge clk); bIf.phase1_done = 1'b1;
        @(negedge clk); bIf.phase1_done = 1'b0;
        begin
            bit seen = 0;
            for (int i = 0; i < 9000 && !seen; i++) begin
                @(negedge clk);
                if (bIf.done) seen = 1;
            end
            checkOutput("bigDoneSeen", 128'(seen), 128'(1));
        end
        repeat (2) @(negedge clk);
        checkOutput("bigUda2", 128'(bUda2), 128'(8192));
        checkOutput("bigRd2", 128'(bRd2), 128'(2048));
        checkOutput("bigLastAddr2", 128'(bLastAddr), 128'(2047));
        checkOutput("bigDoneCount", 128'(bDone), 128'(1));
        checkOutput("bigIdle", 128'(bIf.busy), 128'(0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog actual=timeout required=finish");
        $fatal(1, "[TB] watchdog expired");
    end
endmodule

// File: doc/particle_stream_feeder.md
# particle_stream_feeder

Upstream sequencer for the long-range electrostatics top. It reads packed particle records ({x, y, z, q}, 4×32 bit) from a local particle RAM and streams them to the electrostatics top in two passes: phase 1 for charge spreading and phase 2 for force interpolation. The feeder drives the top's `start_sig`, `user_buffer_data` and `user_data_available` inputs at a fixed word pacing. Between the passes it waits on the top's phase-1 completion.

## Interface
- `NUM_PARTICLES`, 2048, words streamed per pass (≥1)
- `ADDR_WIDTH`, 11, particle RAM address width; NUM_PARTICLES ≤ 2^ADDR_WIDTH
- `DATA_WIDTH`, 128, record width
- `WORD_INTERVAL`, 4, cycles each word is held on the output (≥2)
- `LEAD_CYCLES`, 5, cycles between `start_sig` change and the first valid word (≥2)

Ports:
- `clk`  in  1  single clock; all logic on the rising edge
- `rst`  in  1  asynchronous, active-low reset
- `go`  in  1  start request, sampled only in IDLE
- `phase1_done`  in  1  single-cycle pulse from the top: phase-1 processing complete
- `mem_rd_en`  out  1  particle RAM read enable (registered)
- `mem_rd_addr`  out  ADDR_WIDTH  particle RAM read address (registered)
- `mem_rd_data`  in  DATA_WIDTH  read data, valid exactly one cycle after `mem_rd_en`
- `start_sig`  out  2  phase select to the top: 0 idle, 1 pass 1, 2 pass 2
- `user_buffer_data`  out  DATA_WIDTH  streamed particle record
- `user_data_available`  out  1  high for the whole stream window of a pass
- `busy`  out  1  high in every state except IDLE
- `done`  out  1  one-cycle pulse at end of pass 2

## Operation
- States: IDLE → ARM → STREAM → WAIT → ARM → STREAM → FIN → IDLE. A `pass` bit selects 1 or 2.
- **IDLE**
  - `go`=1 sets `pass`=1 and `start_sig`=1, then enters ARM.
  - `go` outside IDLE is ignored.
- **ARM**
  - Lasts LEAD_CYCLES cycles.
  - First ARM cycle: `mem_rd_en`=1 with `mem_rd_addr`=0.
  - The returned data is captured into the prefetch register on the next cycle.
- **STREAM**
  - Word k (k = 0..NUM_PARTICLES−1) is loaded from prefetch into `user_buffer_data` and held for WORD_INTERVAL cycles.
  - In the first cycle of word k's interval, when k+1 < NUM_PARTICLES: `mem_rd_en`=1, `mem_rd_addr`=k+1.
  - `user_data_available`=1 continuously from word 0 until the end of the last word's interval. There is no gap between words.
  - The word counter is ADDR_WIDTH+1 bits wide, so NUM_PARTICLES = 2^ADDR_WIDTH does not wrap. The address never exceeds NUM_PARTICLES−1.
- **End of a pass**
  - `user_data_available` drops to 0.
  - `user_buffer_data` holds the last word.
  - Pass 1 then goes to WAIT; pass 2 goes to FIN.
- **WAIT**
  - Entered with the latched `phase1_done` flag set, or when `phase1_done` is seen: next cycle `start_sig`=2, `pass`=2, enter ARM.
  - `phase1_done` arriving during pass-1 ARM/STREAM is latched (sticky) and consumed on WAIT entry.
  - `phase1_done` in IDLE, in pass 2 or in FIN is ignored and not latched.
- **FIN**
  - One cycle: `done`=1, `start_sig`=0, then IDLE.
- `mem_rd_en` is 0 in all cycles not listed above.
- **Reset**
  - `rst`=0 in any state asynchronously forces IDLE and all outputs to 0, including `user_buffer_data`, the prefetch register, `pass`, counters and the latched flag.
  - A mid-stream reset abandons the pass; no `done` is issued.

## Timing
- Let `go` be sampled at edge T0.
  - T0+1: `start_sig`=1, `mem_rd_en`=1, addr 0.
  - Word 0 is valid from cycle T0+LEAD_CYCLES+1.
  - Word k is valid from cycle T0+LEAD_CYCLES+1+k·WORD_INTERVAL.
  - `user_data_available` falls at cycle T0+LEAD_CYCLES+1+NUM_PARTICLES·WORD_INTERVAL.
- Pass 2 follows the same formula, with T0 replaced by the cycle `phase1_done` is accepted in WAIT (or the WAIT-entry cycle when the flag was pre-latched).
- FIN (`done`=1, `start_sig`=0) is the cycle in which pass-2 `user_data_available` falls.
- Reset values of all outputs are 0.

## Test plan
- **Basic two-pass:** NUM_PARTICLES=4, WORD_INTERVAL=4, LEAD_CYCLES=5, RAM[i]={i,i,i,0}; `go` at T0, `phase1_done` 20 cycles after pass 1 ends.
  - `start_sig` =1 then =2 at the stated cycles.
  - Words 0..3, each held exactly 4 cycles per pass.
  - `done` is a single pulse; `start_sig`=0 afterwards.
- **Early completion:** pulse `phase1_done` during pass-1 STREAM → pass 2 ARM begins the cycle after WAIT entry.
- **Read protocol:** monitor `mem_rd_en`/`mem_rd_addr` → exactly 4 reads per pass, addresses 0,1,2,3, never ≥4, each one cycle before capture.
- **Ignored inputs:**
  - `go` asserted during STREAM → no restart, counts unchanged.
  - `phase1_done` while IDLE, then `go` → pass 1 completes and the feeder still waits in WAIT.
- **Reset mid-stream:** drop `rst` while word 2 is presented in pass 1 → all outputs 0 immediately, IDLE, no `done`; a subsequent `go` restarts cleanly from word 0.
- **Full size:** NUM_PARTICLES=2048, ADDR_WIDTH=11 → 2048 words per pass, last address 2047, no counter wrap, `user_data_available` high for 8192 cycles per pass.
